// File: rtl/pipe_alu_pkg.sv
// Shared types and defaults for the forwarding pipelined ALU:
// opcode encoding, the illegal opcode constant, stage control records
// and the default geometry used by the interface and the top.
package pipe_alu_pkg;

    localparam int P_DATA_W    = 16;
    localparam int P_NREG      = 16;
    localparam int P_MEM_DEPTH = 256;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_MUL     = 4'd2,
        ALU_SELA    = 4'd3,
        ALU_SELB    = 4'd4,
        ALU_AND     = 4'd5,
        ALU_OR      = 4'd6,
        ALU_XOR     = 4'd7,
        ALU_NOTA    = 4'd8,
        ALU_NOTB    = 4'd9,
        ALU_SRL     = 4'd10,
        ALU_SLL     = 4'd11,
        ALU_SRA     = 4'd12,
        ALU_ROL     = 4'd13,
        ALU_ROR     = 4'd14,
        ALU_ILLEGAL = 4'd15
    } alu_op_e;

    localparam alu_op_e OP_ILLEGAL = ALU_ILLEGAL;

    // Control part of the fetch record (L12): the opcode still needs decoding.
    typedef struct packed {
        logic    valid;
        alu_op_e op;
    } fetch_ctrl_t;

    // Control part of the result records (L23, L34): decoding is done,
    // only legality matters from here on.
    typedef struct packed {
        logic valid;
        logic illegal;
    } result_ctrl_t;

endpackage

// File: rtl/pipe_alu_fwd_if.sv
// Bus between the instruction sequencer and the ALU pipeline, including
// the debug peek ports into the register file and the scratch memory.
interface pipe_alu_fwd_if import pipe_alu_pkg::*; #(
    parameter int DATA_W = P_DATA_W,
    parameter int REG_AW = $clog2(P_NREG),
    parameter int MEM_AW = $clog2(P_MEM_DEPTH)
);
    logic              in_valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        func;
    logic [MEM_AW-1:0] addr;
    logic              out_valid;
    logic [DATA_W-1:0] out_z;
    logic [MEM_AW-1:0] out_addr;
    logic              out_zero;
    logic              out_carry;
    logic              out_illegal;
    logic [REG_AW-1:0] dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;
    logic [MEM_AW-1:0] dbg_maddr;
    logic [DATA_W-1:0] dbg_mdata;

    modport master (
        output in_valid, rs1, rs2, rd, func, addr, dbg_raddr, dbg_maddr,
        input  out_valid, out_z, out_addr, out_zero, out_carry, out_illegal,
               dbg_rdata, dbg_mdata
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, func, addr, dbg_raddr, dbg_maddr,
        output out_valid, out_z, out_addr, out_zero, out_carry, out_illegal,
               dbg_rdata, dbg_mdata
    );
endinterface

// File: rtl/pipe_alu_exec.sv
// Purely combinational ALU core used in the execute stage.
// Illegal opcodes produce a zero result and raise o_illegal.
module pipe_alu_exec import pipe_alu_pkg::*; #(
    parameter int DATA_W = P_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_op_e           i_func,
    output logic [DATA_W-1:0] o_z,
    output logic              o_carry,
    output logic              o_zero,
    output logic              o_illegal
);

    logic [DATA_W:0] w_sum;

    // Decode the opcode into a result; carry only means something for ADD/SUB.
    always_comb begin
        w_sum     = {1'b0, i_a} + {1'b0, i_b};
        o_z       = '0;
        o_carry   = 1'b0;
        o_illegal = (i_func == OP_ILLEGAL);
        case (i_func)
            ALU_ADD: begin
                o_z     = w_sum[DATA_W-1:0];
                o_carry = w_sum[DATA_W];
            end
            ALU_SUB: begin
                o_z     = i_a - i_b;
                o_carry = (i_a < i_b);
            end
            ALU_MUL:  o_z = i_a * i_b;
            ALU_SELA: o_z = i_a;
            ALU_SELB: o_z = i_b;
            ALU_AND:  o_z = i_a & i_b;
            ALU_OR:   o_z = i_a | i_b;
            ALU_XOR:  o_z = i_a ^ i_b;
            ALU_NOTA: o_z = ~i_a;
            ALU_NOTB: o_z = ~i_b;
            ALU_SRL:  o_z = {1'b0, i_a[DATA_W-1:1]};
            ALU_SLL:  o_z = {i_a[DATA_W-2:0], 1'b0};
            ALU_SRA:  o_z = {i_a[DATA_W-1], i_a[DATA_W-1:1]};
            ALU_ROL:  o_z = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
            ALU_ROR:  o_z = {i_a[0], i_a[DATA_W-1:1]};
            default:  o_z = '0;
        endcase
        o_zero = (o_z == '0);
    end

endmodule

// File: rtl/pipe_alu_fwd.sv
// Four-stage register-file ALU: fetch (L12), execute with operand
// forwarding (L23), writeback/output (L34), scratch-memory store.
// Forwarding from L23 then L34 makes dependent ops issue back to back.
module pipe_alu_fwd import pipe_alu_pkg::*; #(
    parameter int DATA_W    = P_DATA_W,
    parameter int NREG      = P_NREG,
    parameter int MEM_DEPTH = P_MEM_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    pipe_alu_fwd_if.slave  bus
);

    localparam int REG_AW = $clog2(NREG);
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] r_mem  [MEM_DEPTH];

    fetch_ctrl_t       r_l12Ctrl;
    logic [DATA_W-1:0] r_l12A;
    logic [DATA_W-1:0] r_l12B;
    logic [REG_AW-1:0] r_l12Rs1;
    logic [REG_AW-1:0] r_l12Rs2;
    logic [REG_AW-1:0] r_l12Rd;
    logic [MEM_AW-1:0] r_l12Addr;

    result_ctrl_t      r_l23Ctrl;
    logic [DATA_W-1:0] r_l23Z;
    logic              r_l23Carry;
    logic              r_l23Zero;
    logic [REG_AW-1:0] r_l23Rd;
    logic [MEM_AW-1:0] r_l23Addr;

    result_ctrl_t      r_l34Ctrl;
    logic [DATA_W-1:0] r_l34Z;
    logic              r_l34Carry;
    logic              r_l34Zero;
    logic [REG_AW-1:0] r_l34Rd;
    logic [MEM_AW-1:0] r_l34Addr;

    logic              w_l23Live;
    logic              w_l34Live;
    logic [DATA_W-1:0] w_opA;
    logic [DATA_W-1:0] w_opB;
    logic [DATA_W-1:0] w_z;
    logic              w_carry;
    logic              w_zero;
    logic              w_illegal;

    assign w_l23Live = r_l23Ctrl.valid && !r_l23Ctrl.illegal;
    assign w_l34Live = r_l34Ctrl.valid && !r_l34Ctrl.illegal;

    // S1: latch operands and instruction fields; a bubble just clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l12Ctrl <= '0;
            r_l12A    <= '0;
            r_l12B    <= '0;
            r_l12Rs1  <= '0;
            r_l12Rs2  <= '0;
            r_l12Rd   <= '0;
            r_l12Addr <= '0;
        end else begin
            r_l12Ctrl.valid <= bus.in_valid;
            r_l12Ctrl.op    <= alu_op_e'(bus.func);
            r_l12A          <= r_regs[bus.rs1];
            r_l12B          <= r_regs[bus.rs2];
            r_l12Rs1        <= bus.rs1;
            r_l12Rs2        <= bus.rs2;
            r_l12Rd         <= bus.rd;
            r_l12Addr       <= bus.addr;
        end
    end

    // Operand forwarding: the younger in-flight producer (L23) beats L34.
    always_comb begin
        w_opA = r_l12A;
        w_opB = r_l12B;
        if (w_l23Live && r_l23Rd == r_l12Rs1) begin
            w_opA = r_l23Z;
        end else if (w_l34Live && r_l34Rd == r_l12Rs1) begin
            w_opA = r_l34Z;
        end
        if (w_l23Live && r_l23Rd == r_l12Rs2) begin
            w_opB = r_l23Z;
        end else if (w_l34Live && r_l34Rd == r_l12Rs2) begin
            w_opB = r_l34Z;
        end
    end

    pipe_alu_exec #(.DATA_W(DATA_W)) u_exec (
        .i_a       (w_opA),
        .i_b       (w_opB),
        .i_func    (r_l12Ctrl.op),
        .o_z       (w_z),
        .o_carry   (w_carry),
        .o_zero    (w_zero),
        .o_illegal (w_illegal)
    );

    // S2: register the ALU result; bubbles carry don't-care data with valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l23Ctrl  <= '0;
            r_l23Z     <= '0;
            r_l23Carry <= 1'b0;
            r_l23Zero  <= 1'b0;
            r_l23Rd    <= '0;
            r_l23Addr  <= '0;
        end else begin
            r_l23Ctrl.valid   <= r_l12Ctrl.valid;
            r_l23Ctrl.illegal <= w_illegal;
            r_l23Z            <= w_z;
            r_l23Carry        <= w_carry;
            r_l23Zero         <= w_zero;
            r_l23Rd           <= r_l12Rd;
            r_l23Addr         <= r_l12Addr;
        end
    end

    // S3: output register; data fields only move on a valid op so the outputs hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l34Ctrl  <= '0;
            r_l34Z     <= '0;
            r_l34Carry <= 1'b0;
            r_l34Zero  <= 1'b0;
            r_l34Rd    <= '0;
            r_l34Addr  <= '0;
        end else begin
            r_l34Ctrl <= r_l23Ctrl;
            if (r_l23Ctrl.valid) begin
                r_l34Z     <= r_l23Z;
                r_l34Carry <= r_l23Carry;
                r_l34Zero  <= r_l23Zero;
                r_l34Rd    <= r_l23Rd;
                r_l34Addr  <= r_l23Addr;
            end
        end
    end

    // S3: register file writeback, skipped for bubbles and illegal ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_l23Live) begin
            r_regs[r_l23Rd] <= r_l23Z;
        end
    end

    // S4: scratch-memory store; memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_l34Live) begin
            r_mem[r_l34Addr] <= r_l34Z;
        end
    end

    assign bus.out_valid   = r_l34Ctrl.valid;
    assign bus.out_illegal = r_l34Ctrl.valid && r_l34Ctrl.illegal;
    assign bus.out_z       = r_l34Z;
    assign bus.out_zero    = r_l34Zero;
    assign bus.out_carry   = r_l34Carry;
    assign bus.out_addr    = r_l34Addr;
    assign bus.dbg_rdata   = r_regs[bus.dbg_raddr];
    assign bus.dbg_mdata   = r_mem[bus.dbg_maddr];

endmodule

// File: tb/tb_pipe_alu_fwd.sv
// Scoreboard bench for pipe_alu_fwd: the driver computes each expected
// result from an architectural (in-order, no-pipeline) model and queues it;
// an independent monitor pops and compares whenever out_valid is seen.
module tb_pipe_alu_fwd;
    import pipe_alu_pkg::*;

    localparam longint M = 65536;
    localparam int F_ADD = 0, F_SUB = 1, F_MUL = 2, F_SELA = 3, F_SELB = 4;
    localparam int F_AND = 5, F_OR = 6, F_XOR = 7, F_NOTA = 8, F_NOTB = 9;
    localparam int F_SRL = 10, F_SLL = 11, F_SRA = 12, F_ROL = 13, F_ROR = 14;
    localparam int F_ILL = 15;

    typedef struct {
        logic [15:0] z;
        logic        carry;
        logic        zero;
        logic        illegal;
        logic [7:0]  addr;
        int          acceptEdge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t        expQ[$];
    exp_t        monE;
    logic [15:0] regModel [16];
    logic [15:0] memModel [256];
    bit          memKnown [256];
    logic [15:0] lastZ = '0;
    logic        lastZero = 1'b0;
    logic        lastCarry = 1'b0;
    int          nChecks = 0;
    int          nFails = 0;
    int          cycCnt = 0;

    pipe_alu_fwd_if bus ();

    pipe_alu_fwd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycCnt <= cycCnt + 1;

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Architectural meaning of each opcode, written as plain integer arithmetic.
    function automatic void refAlu(input int f, input longint a, input longint b,
                                   output logic [15:0] z, output logic carry,
                                   output logic illegal);
        longint r;
        r = 0;
        carry = 1'b0;
        illegal = 1'b0;
        case (f)
            F_ADD:  begin r = a + b; carry = (r >= M); end
            F_SUB:  begin r = a - b; carry = (a < b); if (r < 0) r = r + M; end
            F_MUL:  r = a * b;
            F_SELA: r = a;
            F_SELB: r = b;
            F_AND:  r = a & b;
            F_OR:   r = a | b;
            F_XOR:  r = a ^ b;
            F_NOTA: r = M - 1 - a;
            F_NOTB: r = M - 1 - b;
            F_SRL:  r = a / 2;
            F_SLL:  r = a * 2;
            F_SRA:  r = a / 2 + ((a >= M / 2) ? M / 2 : 0);
            F_ROL:  r = a * 2 + a / (M / 2);
            F_ROR:  r = a / 2 + (a % 2) * (M / 2);
            default: illegal = 1'b1;
        endcase
        z = 16'(r % M);
    endfunction

    task automatic applyStimulus(input bit v, input int rs1, input int rs2,
                                 input int rd, input int f, input int a);
        exp_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.rs1      = 4'(rs1);
        bus.rs2      = 4'(rs2);
        bus.rd       = 4'(rd);
        bus.func     = 4'(f);
        bus.addr     = 8'(a);
        if (v) begin
            refAlu(f, longint'(regModel[rs1]), longint'(regModel[rs2]), e.z, e.carry, e.illegal);
            e.zero       = (e.z == 16'h0);
            e.addr       = 8'(a);
            e.acceptEdge = cycCnt + 1;
            if (!e.illegal) regModel[rd] = e.z;
            expQ.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic bubble();
        applyStimulus(1'b0, $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
    endtask

    task automatic drain();
        int budget = 12;
        while (expQ.size() != 0 && budget > 0) begin
            bubble();
            budget--;
        end
        checkOutput("drain_pending", expQ.size(), 0);
        expQ.delete();
        bubble();
        bubble();
    endtask

    task automatic checkReg(input int idx, input logic [15:0] exp, input string name);
        bus.dbg_raddr = 4'(idx);
        #1;
        checkOutput($sformatf("%s_r%0d", name, idx), bus.dbg_rdata, exp);
    endtask

    task automatic checkMem(input int a, input logic [15:0] exp, input string name);
        bus.dbg_maddr = 8'(a);
        #1;
        checkOutput($sformatf("%s_m%0h", name, a), bus.dbg_mdata, exp);
    endtask

    // Monitor: every valid output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out_valid", bus.out_valid, 0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("out_z", bus.out_z, monE.z);
                    checkOutput("out_carry", bus.out_carry, monE.carry);
                    checkOutput("out_zero", bus.out_zero, monE.zero);
                    checkOutput("out_illegal", bus.out_illegal, monE.illegal);
                    checkOutput("out_addr", bus.out_addr, monE.addr);
                    checkOutput("latency", cycCnt - monE.acceptEdge, 2);
                    lastZ     = monE.z;
                    lastZero  = monE.zero;
                    lastCarry = monE.carry;
                    if (!monE.illegal) begin
                        memModel[monE.addr] = monE.z;
                        memKnown[monE.addr] = 1'b1;
                    end
                end
            end else begin
                checkOutput("out_valid_idle", bus.out_valid, 0);
                checkOutput("illegal_idle", bus.out_illegal, 0);
                checkOutput("hold_z", bus.out_z, lastZ);
                checkOutput("hold_zero", bus.out_zero, lastZero);
                checkOutput("hold_carry", bus.out_carry, lastCarry);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) regModel[i] = '0;
        for (int i = 0; i < 256; i++) memKnown[i] = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.rd        = '0;
        bus.func      = '0;
        bus.addr      = '0;
        bus.dbg_raddr = '0;
        bus.dbg_maddr = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_z", bus.out_z, 0);
        checkOutput("rst_out_zero", bus.out_zero, 0);
        checkOutput("rst_out_carry", bus.out_carry, 0);
        checkOutput("rst_out_illegal", bus.out_illegal, 0);
        checkOutput("rst_out_addr", bus.out_addr, 0);
        for (int i = 0; i < 16; i++) checkReg(i, 16'h0000, "rst");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single op after reset.
        applyStimulus(1, 0, 0, 1, F_ADD, 0);
        drain();
        checkReg(1, 16'h0000, "single_add");

        // Build r2=3, then a back-to-back dependent chain.
        applyStimulus(1, 0, 0, 10, F_NOTA, 1);
        applyStimulus(1, 0, 10, 11, F_SUB, 2);
        applyStimulus(1, 11, 11, 12, F_ADD, 3);
        applyStimulus(1, 12, 11, 2, F_ADD, 4);
        applyStimulus(1, 2, 0, 13, F_SELA, 5);
        applyStimulus(1, 2, 2, 3, F_ADD, 6);
        applyStimulus(1, 3, 2, 4, F_ADD, 7);
        applyStimulus(1, 4, 3, 5, F_ADD, 8);
        drain();
        checkReg(2, 16'h0003, "chain");
        checkReg(3, 16'h0006, "chain");
        checkReg(4, 16'h0009, "chain");
        checkReg(5, 16'h000F, "chain");

        // Flags and wrap-around.
        applyStimulus(1, 10, 0, 6, F_SELA, 9);
        applyStimulus(1, 11, 0, 7, F_SELA, 10);
        applyStimulus(1, 6, 7, 8, F_ADD, 11);
        applyStimulus(1, 7, 6, 9, F_SUB, 12);
        applyStimulus(1, 11, 0, 14, F_SLL, 13);
        repeat (7) applyStimulus(1, 14, 0, 14, F_SLL, 13);
        applyStimulus(1, 14, 14, 15, F_MUL, 14);
        drain();
        checkReg(8, 16'h0000, "add_wrap");
        checkReg(9, 16'h0002, "sub_borrow");
        checkReg(14, 16'h0100, "sll_chain");
        checkReg(15, 16'h0000, "mul_trunc");

        // Shifts and rotates on 0x8001.
        applyStimulus(1, 0, 0, 13, F_NOTA, 20);
        applyStimulus(1, 13, 0, 13, F_SRL, 21);
        applyStimulus(1, 13, 0, 13, F_NOTA, 22);
        applyStimulus(1, 13, 11, 13, F_OR, 23);
        applyStimulus(1, 13, 0, 1, F_SRL, 24);
        applyStimulus(1, 13, 0, 2, F_SRA, 25);
        applyStimulus(1, 13, 0, 3, F_ROL, 26);
        applyStimulus(1, 13, 0, 4, F_ROR, 27);
        applyStimulus(1, 13, 0, 5, F_SLL, 28);
        drain();
        checkReg(13, 16'h8001, "shift_src");
        checkReg(1, 16'h4000, "srl");
        checkReg(2, 16'hC000, "sra");
        checkReg(3, 16'h0003, "rol");
        checkReg(4, 16'hC000, "ror");
        checkReg(5, 16'h0002, "sll");

        // Illegal op and bubbles leave state untouched.
        applyStimulus(1, 1, 0, 1, F_SELA, 8'h20);
        applyStimulus(1, 3, 4, 2, F_ILL, 8'h20);
        drain();
        checkReg(2, 16'hC000, "illegal_rd");
        checkMem(8'h20, 16'h4000, "illegal_mem");
        repeat (6) bubble();
        checkReg(2, 16'hC000, "bubble_rd");
        checkMem(8'h20, 16'h4000, "bubble_mem");

        // Store to the top address, visible four edges after issue.
        applyStimulus(1, 7, 7, 6, F_ADD, 8'hFF);
        repeat (3) bubble();
        checkMem(8'hFF, 16'h0002, "mem_top");

        // Randomized traffic against the architectural model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bubble();
            end else begin
                applyStimulus(1, $urandom_range(0, 15), $urandom_range(0, 15),
                              $urandom_range(0, 15), $urandom_range(0, 15),
                              $urandom_range(0, 255));
            end
        end
        drain();
        for (int i = 0; i < 16; i++) checkReg(i, regModel[i], "rand_reg");
        for (int i = 0; i < 256; i++) begin
            if (memKnown[i]) checkMem(i, memModel[i], "rand_mem");
        end

        // Reset while a store to 0x10 is in flight.
        applyStimulus(1, 5, 0, 5, F_SELA, 8'h10);
        drain();
        applyStimulus(1, 5, 0, 6, F_NOTA, 8'h10);
        bubble();
        #1 rst = 1'b1;
        expQ.delete();
        for (int i = 0; i < 16; i++) regModel[i] = '0;
        lastZ     = '0;
        lastZero  = 1'b0;
        lastCarry = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_out_z", bus.out_z, 0);
        checkMem(8'h10, memModel[8'h10], "midrst_mem");
        for (int i = 0; i < 16; i++) checkReg(i, 16'h0000, "midrst");
        @(posedge clk);
        #1 rst = 1'b0;

        // Issue on the very first edge after reset release.
        applyStimulus(1, 0, 0, 3, F_NOTA, 8'h11);
        applyStimulus(1, 3, 3, 4, F_ADD, 8'h12);
        drain();
        checkReg(3, 16'hFFFF, "post_rst");
        checkReg(4, 16'hFFFE, "post_rst");
        checkMem(8'h10, memModel[8'h10], "post_rst_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
